// File: rtl/flit_source_sink.sv
// Flit traffic pair: a source sends MAX_FLITS counted flits to a sink over a 4-phase req/ack link.
// Optional macro FLIT_CHECK_EN adds a sticky sequence checker on the sink side (mismatch output).
module flit_source_sink #(
  parameter int unsigned SIZE      = 8,
  parameter int unsigned MAX_FLITS = 5,
  parameter int unsigned CW        = (MAX_FLITS > 0) ? $clog2(MAX_FLITS + 1) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sink_stall,
  input  logic            corrupt,
  output logic            link_req,
  output logic            link_ack,
  output logic [SIZE-1:0] link_data,
  output logic [CW-1:0]   sent_count,
  output logic [CW-1:0]   recv_count,
  output logic [SIZE-1:0] last_data,
  output logic            src_done,
  output logic            mismatch
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL, S_DONE} src_state_e;
  typedef enum logic {K_IDLE, K_ACK} snk_state_e;

  src_state_e      s_state_q, s_state_d;
  snk_state_e      k_state_q, k_state_d;
  logic            link_req_q, link_req_d;
  logic            link_ack_q, link_ack_d;
  logic [SIZE-1:0] link_data_q, link_data_d;
  logic [CW-1:0]   sent_count_q, sent_count_d;
  logic [CW-1:0]   recv_count_q, recv_count_d;
  logic [SIZE-1:0] last_data_q, last_data_d;
  logic            src_done_q, src_done_d;
  logic            launch_c;
  logic            cap_c;
  logic [SIZE-1:0] rx_data_c;

  // Data as the sink sees it, with optional bit-0 fault injection
  assign rx_data_c = corrupt ? (link_data_q ^ SIZE'(1)) : link_data_q;
  assign cap_c     = (k_state_q == K_IDLE) && link_req_q && !sink_stall;

  // Source next-state; S_REL falls through to the idle launch decision once ack drops
  always_comb begin
    s_state_d    = s_state_q;
    link_req_d   = link_req_q;
    link_data_d  = link_data_q;
    sent_count_d = sent_count_q;
    src_done_d   = src_done_q;
    launch_c     = 1'b0;
    case (s_state_q)
      S_IDLE: launch_c = 1'b1;
      S_REQ: begin
        if (link_ack_q) begin
          link_req_d   = 1'b0;
          sent_count_d = sent_count_q + CW'(1);
          s_state_d    = S_REL;
        end
      end
      S_REL:   launch_c = !link_ack_q;
      S_DONE:  s_state_d = S_DONE;
      default: s_state_d = S_IDLE;
    endcase
    if (launch_c) begin
      if (sent_count_q == CW'(MAX_FLITS)) begin
        src_done_d = 1'b1;
        s_state_d  = S_DONE;
      end else begin
        link_data_d = SIZE'(sent_count_q);
        link_req_d  = 1'b1;
        s_state_d   = S_REQ;
      end
    end
  end

  // Sink next-state
  always_comb begin
    k_state_d    = k_state_q;
    link_ack_d   = link_ack_q;
    recv_count_d = recv_count_q;
    last_data_d  = last_data_q;
    case (k_state_q)
      K_IDLE: begin
        if (cap_c) begin
          last_data_d  = rx_data_c;
          link_ack_d   = 1'b1;
          recv_count_d = recv_count_q + CW'(1);
          k_state_d    = K_ACK;
        end
      end
      K_ACK: begin
        if (!link_req_q) begin
          link_ack_d = 1'b0;
          k_state_d  = K_IDLE;
        end
      end
      default: k_state_d = K_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_state_q    <= S_IDLE;
      k_state_q    <= K_IDLE;
      link_req_q   <= 1'b0;
      link_ack_q   <= 1'b0;
      link_data_q  <= '0;
      sent_count_q <= '0;
      recv_count_q <= '0;
      last_data_q  <= '0;
      src_done_q   <= 1'b0;
    end else begin
      s_state_q    <= s_state_d;
      k_state_q    <= k_state_d;
      link_req_q   <= link_req_d;
      link_ack_q   <= link_ack_d;
      link_data_q  <= link_data_d;
      sent_count_q <= sent_count_d;
      recv_count_q <= recv_count_d;
      last_data_q  <= last_data_d;
      src_done_q   <= src_done_d;
    end
  end

`ifdef FLIT_CHECK_EN
  logic [SIZE-1:0] exp_data_q, exp_data_d;
  logic            mismatch_q, mismatch_d;

  // Expected sequence advances on every capture, so one bad flit flags once and later flits realign
  always_comb begin
    exp_data_d = exp_data_q;
    mismatch_d = mismatch_q;
    if (cap_c) begin
      exp_data_d = exp_data_q + SIZE'(1);
      if (rx_data_c != exp_data_q) mismatch_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_data_q <= '0;
      mismatch_q <= 1'b0;
    end else begin
      exp_data_q <= exp_data_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

  assign link_req   = link_req_q;
  assign link_ack   = link_ack_q;
  assign link_data  = link_data_q;
  assign sent_count = sent_count_q;
  assign recv_count = recv_count_q;
  assign last_data  = last_data_q;
  assign src_done   = src_done_q;

endmodule

// File: tb/tb_flit_source_sink.sv
// Directed bench for flit_source_sink: default, SIZE=3/MAX_FLITS=10 and MAX_FLITS=0 instances.
module tb_flit_source_sink;

`ifdef FLIT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // dut0: default parameters, full stimulus control
  logic       rst0, stall0, corrupt0;
  logic       req0, ack0, done0, mis0;
  logic [7:0] data0, last0;
  logic [2:0] sent0, recv0;

  // dut1: narrow data with wrap, dut2: zero flits
  logic       rst1;
  logic       req1, ack1, done1, mis1;
  logic [2:0] data1, last1;
  logic [3:0] sent1, recv1;
  logic       req2, ack2, done2, mis2;
  logic [7:0] data2, last2;
  logic [0:0] sent2, recv2;

  flit_source_sink u_dut0 (
    .clk(clk), .reset(rst0), .sink_stall(stall0), .corrupt(corrupt0),
    .link_req(req0), .link_ack(ack0), .link_data(data0),
    .sent_count(sent0), .recv_count(recv0), .last_data(last0),
    .src_done(done0), .mismatch(mis0)
  );

  flit_source_sink #(.SIZE(3), .MAX_FLITS(10)) u_dut1 (
    .clk(clk), .reset(rst1), .sink_stall(1'b0), .corrupt(1'b0),
    .link_req(req1), .link_ack(ack1), .link_data(data1),
    .sent_count(sent1), .recv_count(recv1), .last_data(last1),
    .src_done(done1), .mismatch(mis1)
  );

  flit_source_sink #(.MAX_FLITS(0)) u_dut2 (
    .clk(clk), .reset(rst1), .sink_stall(1'b0), .corrupt(1'b0),
    .link_req(req2), .link_ack(ack2), .link_data(data2),
    .sent_count(sent2), .recv_count(recv2), .last_data(last2),
    .src_done(done2), .mismatch(mis2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Unstalled link timeline: edge e after reset release (e=0 is the reset state)
  function automatic void model(input int e, input int maxf, input int size,
                                output int req, output int ack, output int data,
                                output int sent, output int recv, output int done,
                                output int last);
    int k, p, m;
    m = 1 << size;
    req = 0; ack = 0; data = 0; sent = 0; recv = 0; done = 0;
    if (e >= 1) begin
      k = (e - 1) / 4;
      p = (e - 1) % 4;
      if (k < maxf) begin
        req  = (p <= 1) ? 1 : 0;
        ack  = (p == 1 || p == 2) ? 1 : 0;
        sent = k + ((p >= 2) ? 1 : 0);
        recv = k + ((p >= 1) ? 1 : 0);
        data = k % m;
      end else begin
        sent = maxf;
        recv = maxf;
        done = 1;
        data = (maxf > 0) ? (maxf - 1) % m : 0;
      end
    end
    last = (recv > 0) ? (recv - 1) % m : 0;
  endfunction

  task automatic chk_d0(input string ph, input int e_tag, input int e_mod,
                        input int mis_exp, input int last_ovr);
    int rq, ak, dt, st, rc, dn, ls;
    model(e_mod, 5, 8, rq, ak, dt, st, rc, dn, ls);
    if (last_ovr >= 0) ls = last_ovr;
    check($sformatf("%s d0 req e%0d", ph, e_tag),  32'(req0),  32'(rq));
    check($sformatf("%s d0 ack e%0d", ph, e_tag),  32'(ack0),  32'(ak));
    check($sformatf("%s d0 data e%0d", ph, e_tag), 32'(data0), 32'(dt));
    check($sformatf("%s d0 sent e%0d", ph, e_tag), 32'(sent0), 32'(st));
    check($sformatf("%s d0 recv e%0d", ph, e_tag), 32'(recv0), 32'(rc));
    check($sformatf("%s d0 done e%0d", ph, e_tag), 32'(done0), 32'(dn));
    check($sformatf("%s d0 last e%0d", ph, e_tag), 32'(last0), 32'(ls));
    check($sformatf("%s d0 mis e%0d", ph, e_tag),  32'(mis0),  32'(mis_exp));
  endtask

  task automatic chk_d12(input int e);
    int rq, ak, dt, st, rc, dn, ls;
    model(e, 10, 3, rq, ak, dt, st, rc, dn, ls);
    check($sformatf("d1 req e%0d", e),  32'(req1),  32'(rq));
    check($sformatf("d1 ack e%0d", e),  32'(ack1),  32'(ak));
    check($sformatf("d1 data e%0d", e), 32'(data1), 32'(dt));
    check($sformatf("d1 sent e%0d", e), 32'(sent1), 32'(st));
    check($sformatf("d1 recv e%0d", e), 32'(recv1), 32'(rc));
    check($sformatf("d1 done e%0d", e), 32'(done1), 32'(dn));
    check($sformatf("d1 last e%0d", e), 32'(last1), 32'(ls));
    check($sformatf("d1 mis e%0d", e),  32'(mis1),  32'(0));
    check($sformatf("d2 req e%0d", e),  32'(req2),  32'(0));
    check($sformatf("d2 ack e%0d", e),  32'(ack2),  32'(0));
    check($sformatf("d2 sent e%0d", e), 32'(sent2), 32'(0));
    check($sformatf("d2 recv e%0d", e), 32'(recv2), 32'(0));
    check($sformatf("d2 done e%0d", e), 32'(done2), 32'((e >= 1) ? 1 : 0));
    check($sformatf("d2 mis e%0d", e),  32'(mis2),  32'(0));
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; stall0 = 1'b0; corrupt0 = 1'b0;

    // Free-running traffic on all three instances
    tick();
    rst0 = 1'b0; rst1 = 1'b0;
    chk_d0("p1", 0, 0, 0, -1);
    chk_d12(0);
    for (int e = 1; e <= 45; e++) begin
      tick();
      chk_d0("p1", e, e, 0, -1);
      chk_d12(e);
    end

    // Back-pressure over edges 1..9 delays the whole timeline by 8 edges
    rst0 = 1'b1; stall0 = 1'b1;
    tick();
    rst0 = 1'b0;
    chk_d0("p2", 0, 0, 0, -1);
    for (int e = 1; e <= 33; e++) begin
      tick();
      chk_d0("p2", e, (e <= 9) ? 1 : e - 8, 0, -1);
      if (e == 9) stall0 = 1'b0;
    end

    // Reset in the middle of flit 2 aborts and restarts from flit 0
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      chk_d0("p3a", e, e, 0, -1);
    end
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    chk_d0("p3rst", 10, 0, 0, -1);
    for (int e = 1; e <= 23; e++) begin
      tick();
      chk_d0("p3b", e, e, 0, -1);
    end

    // Bit-0 corruption on the capture of flit 2 (edge 10)
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      tick();
      chk_d0("p4", e, e, (CHK && e >= 10) ? 1 : 0, (e >= 10 && e <= 13) ? 3 : -1);
      corrupt0 = (e == 9);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/flit_source_sink.md
Name: flit_source_sink

Overview:
- Self-contained flit traffic pair: a source stage sends a counted sequence of flits over an internal req/ack 4-phase (return-to-zero) handshake channel to a sink stage.
- The sink acknowledges and counts the flits.
- Link signals and status are exported for observation.
- Used as a handshake/link sanity block and a traffic stub in NoC bring-up benches.

Parameters:
- SIZE, 8, flit data width in bits.
- MAX_FLITS, 5, number of flits the source sends after reset (0 allowed).
- CW, $clog2(MAX_FLITS+1) (minimum 1), width of the flit counters.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- sink_stall  input  1  when 1 the sink does not raise ack (back-pressure).
- corrupt  input  1  when 1 the sink sees link_data with bit 0 inverted (fault injection).
- link_req  output  1  channel req, driven by source.
- link_ack  output  1  channel ack, driven by sink.
- link_data  output  SIZE  channel data, driven by source.
- sent_count  output  CW  flits completed by source (ack seen).
- recv_count  output  CW  flits accepted by sink.
- last_data  output  SIZE  last flit value captured by sink.
- src_done  output  1  source has sent all MAX_FLITS flits.
- mismatch  output  1  sticky data-check error (see Optional Feature).

Behaviour:
- One clock domain; reset is synchronous and active-high. All outputs are registered.
- Reset values: every output is 0. Source state is S_IDLE; sink state is K_IDLE.
- Reset asserted mid-transfer aborts the transfer. All outputs are 0 on the next edge, and the sequence restarts from flit 0 after reset deasserts.
- Source FSM:
  - S_IDLE: if sent_count==MAX_FLITS, go to S_DONE (src_done<=1). Else link_data<=sent_count (zero-extended/truncated to SIZE), link_req<=1, go to S_REQ.
  - S_REQ: link_req and link_data hold stable. On link_ack==1: link_req<=0, sent_count++, go to S_REL.
  - S_REL: wait for link_ack==0, then act as S_IDLE in the same cycle (may raise req immediately).
  - S_DONE: terminal until reset; link_req stays 0 and src_done stays 1.
- Sink FSM:
  - K_IDLE: if link_req==1 and sink_stall==0: capture the (possibly corrupted) data into last_data, link_ack<=1, recv_count++, go to K_ACK.
  - K_ACK: on link_req==0: link_ack<=0, go to K_IDLE. sink_stall is ignored in K_ACK.
- Timing with no stall: reset released before edge 1.
  - Edge 1: req=1, data=0.
  - Edge 2: ack=1.
  - Edge 3: req=0, sent_count=1.
  - Edge 4: ack=0.
  - Edge 5: req=1, data=1.
  - Period is 4 cycles per flit. src_done rises at edge 4*MAX_FLITS+1.
- MAX_FLITS=0: src_done=1 at edge 1; req never asserted.
- Data width: flit value is sent_count mod 2^SIZE. Wrap-around is legal and is not an error.
- Counters never exceed MAX_FLITS. There is no overflow case by construction.
- Handshake invariants:
  - req never rises while ack==1.
  - ack never rises while req==0.
  - data changes only while req==0, or on the cycle req rises.

Optional Feature:
- Macro: FLIT_CHECK_EN.
- Defined:
  - Sink keeps an expected-value register (reset 0).
  - On each capture it compares received data with expected, then increments expected mod 2^SIZE.
  - On inequality, mismatch<=1, sticky until reset.
  - The sink still acks and counts a mismatching flit.
- Not defined: no checker logic; mismatch is tied to 0.

Test Plan:
- Default params, reset for 1 cycle, stall=0, corrupt=0 -> req rises at edges 1,5,9,13,17 with data 0..4; recv_count=5, sent_count=5, last_data=4, src_done=1 at edge 21, mismatch=0; no further req through 250 time units.
- sink_stall=1 during edges 1–9, then 0 -> req=1/data=0 held and ack=0 throughout the stall; ack=1 on the first edge after release; remaining flits keep 4-cycle spacing; totals equal 5.
- Reset pulsed at edge 10 (mid flit 2) -> all outputs 0 on the next edge; after release, flits 0..4 are resent and totals equal 5.
- SIZE=3, MAX_FLITS=10 -> data sequence 0..7,0,1; last_data=1; recv_count=10; mismatch=0 with FLIT_CHECK_EN.
- FLIT_CHECK_EN defined, corrupt=1 during flit 2 only -> last_data=3 at that capture, mismatch=1 and stays 1; recv_count still reaches 5. Without the macro, mismatch stays 0.
- MAX_FLITS=0 -> src_done=1 at edge 1; link_req, link_ack and both counts stay 0.
